shift_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the load/store/shift register. It accepts one shift or load command per valid/ready handshake, with an amount up to 2^AMT_W-1. It breaks the command into register operations of at most 7 bit positions each and drives the register's ctrl, num_shift, data and shift-in pins. It pulses done when the final operation has been issued.

---
 rtl/shift_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer in front of the load/store/shift register: splits one
// load or shift command into register operations of at most MAX_STEP bits.
module shift_cmd_sequencer #(
  parameter int n        = 8,
  parameter int AMT_W    = 4,
  parameter int MAX_STEP = 7
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [n-1:0]     cmd_data,
  input  logic             cmd_fill,
  output logic [1:0]       reg_ctrl,
  output logic [2:0]       reg_num_shift,
  output logic [n-1:0]     reg_data,
  output logic             reg_Ls,
  output logic             reg_Rs,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_RIGHT = 2'b11;

  // Shifting by n or more leaves only fill bits, so amounts clamp to n.
  localparam logic [AMT_W-1:0] SAT_AMT  = (n >= (1 << AMT_W)) ? '1 : AMT_W'(n);
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(MAX_STEP);

  state_t           state;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] eff_amt;
  logic [2:0]       first_step;
  logic [2:0]       next_step;
  logic             xfer;

  function automatic logic [2:0] step_of(input logic [AMT_W-1:0] amt);
    if (amt > STEP_MAX) begin
      step_of = 3'(MAX_STEP);
    end else begin
      step_of = amt[2:0];
    end
  endfunction

  always_comb begin
    eff_amt    = (cmd_amt > SAT_AMT) ? SAT_AMT : cmd_amt;
    first_step = step_of(eff_amt);
    next_step  = step_of(remaining);
    xfer       = cmd_valid && cmd_ready;
  end

  // remaining counts the distance still owed after the operation currently
  // on the register pins, so each step's outputs can be registered ahead.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state         <= IDLE;
      op_q          <= OP_HOLD;
      remaining     <= '0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      reg_ctrl      <= OP_HOLD;
      reg_num_shift <= 3'd0;
      reg_data      <= '0;
      reg_Ls        <= 1'b0;
      reg_Rs        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            op_q      <= cmd_op;
            reg_data  <= cmd_data;
            reg_Ls    <= cmd_fill;
            reg_Rs    <= cmd_fill;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_LOAD: begin
                state         <= ISSUE;
                reg_ctrl      <= OP_LOAD;
                reg_num_shift <= 3'd0;
                remaining     <= '0;
              end
              OP_LEFT, OP_RIGHT: begin
                if (eff_amt == '0) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  remaining <= '0;
                end else begin
                  state         <= ISSUE;
                  reg_ctrl      <= cmd_op;
                  reg_num_shift <= first_step;
                  remaining     <= eff_amt - AMT_W'(first_step);
                end
              end
              default: begin
                state     <= DONE;
                done      <= 1'b1;
                remaining <= '0;
              end
            endcase
          end
        end

        ISSUE: begin
          if (remaining == '0) begin
            state         <= DONE;
            done          <= 1'b1;
            reg_ctrl      <= OP_HOLD;
            reg_num_shift <= 3'd0;
          end else begin
            reg_ctrl      <= op_q;
            reg_num_shift <= next_step;
            remaining     <= remaining - AMT_W'(next_step);
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state         <= IDLE;
          done          <= 1'b0;
          busy          <= 1'b0;
          cmd_ready     <= 1'b1;
          reg_ctrl      <= OP_HOLD;
          reg_num_shift <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer: directed commands push expected
// register operations; a negedge monitor pops and compares them.
module tb_shift_cmd_sequencer;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_amt = '0;
  logic [N-1:0]  cmd_data = '0;
  logic          cmd_fill = 1'b0;
  logic [1:0]    reg_ctrl;
  logic [2:0]    reg_num_shift;
  logic [N-1:0]  reg_data;
  logic          reg_Ls;
  logic          reg_Rs;
  logic          busy;
  logic          done;

  shift_cmd_sequencer #(.n(N), .AMT_W(AW), .MAX_STEP(7)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .reg_ctrl(reg_ctrl), .reg_num_shift(reg_num_shift), .reg_data(reg_data),
    .reg_Ls(reg_Ls), .reg_Rs(reg_Rs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the downstream load/store/shift register.
  logic [7:0] dreg = 8'h00;

  function automatic logic [7:0] nextReg(input logic [7:0] r, input logic [1:0] c,
                                         input logic [2:0] k, input logic [7:0] d,
                                         input logic ls, input logic rs);
    logic [7:0] t;
    t = r;
    case (c)
      2'b01: t = d;
      2'b10: for (int i = 0; i < int'(k); i++) t = {t[6:0], ls};
      2'b11: for (int i = 0; i < int'(k); i++) t = {rs, t[7:1]};
      default: t = r;
    endcase
    return t;
  endfunction

  always @(posedge clk) dreg <= nextReg(dreg, reg_ctrl, reg_num_shift, reg_data, reg_Ls, reg_Rs);

  typedef struct {
    bit         kind;
    int         cyc;
    logic [1:0] ctrl;
    logic [2:0] num;
    logic [7:0] data;
    logic       fill;
    logic [7:0] regval;
  } exp_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [17:0] val;
    logic [17:0] mask;
  } snap_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [7:0]    data;
    logic          fill;
    int            n;
    logic [2:0]    s0;
    logic [2:0]    s1;
    logic [7:0]    regval;
  } vec_t;

  localparam logic [17:0] ALL_MASK  = 18'h3FFFF;
  localparam logic [17:0] CTRL_MASK = 18'h3FC00;
  localparam logic [17:0] RESET_VAL = {1'b1, 17'b0};

  exp_t  sb[$];
  snap_t snap_q[$];
  int    checks = 0;
  int    errors = 0;
  int    timeout_count = 0;
  bit    end_req = 1'b0;
  bit    end_seen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, actual, required);
    end
  endtask

  // Monitor: compares every visible register operation and done pulse
  // against the scoreboard, plus any snapshots scheduled for this cycle.
  exp_t  e;
  snap_t s;
  always @(negedge clk) begin
    if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
      s = snap_q.pop_front();
      checkOutput(s.name,
                  32'({cmd_ready, busy, done, reg_ctrl, reg_num_shift, reg_data, reg_Ls, reg_Rs} & s.mask),
                  32'(s.val & s.mask));
    end
    if (reg_ctrl != 2'b00 || done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_activity", 32'({done, reg_ctrl}), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("kind_done", 32'(done), 32'(e.kind));
        checkOutput("timing_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.kind) begin
          checkOutput("issue_outputs",
                      32'({reg_ctrl, reg_num_shift, reg_Ls, reg_Rs, busy, cmd_ready, done}),
                      32'({e.ctrl, e.num, e.fill, e.fill, 1'b1, 1'b0, 1'b0}));
          if (e.ctrl == 2'b01) checkOutput("load_data", 32'(reg_data), 32'(e.data));
        end else begin
          checkOutput("done_outputs",
                      32'({reg_ctrl, reg_num_shift, busy, cmd_ready, done}),
                      32'({2'b00, 3'd0, 1'b1, 1'b0, 1'b1}));
          checkOutput("register_value", 32'(dreg), 32'(e.regval));
        end
      end
    end
    if (end_req && !end_seen) begin
      end_seen = 1'b1;
      checkOutput("leftover_expected", 32'(sb.size() + snap_q.size()), 32'd0);
      checkOutput("timeouts", 32'(timeout_count), 32'd0);
    end
  end

  task automatic pushSnap(input string name, input int c, input logic [17:0] val, input logic [17:0] mask);
    snap_t t;
    t.cyc = c; t.name = name; t.val = val; t.mask = mask;
    snap_q.push_back(t);
  endtask

  // Drives one command, waits for acceptance and queues its expected operations.
  task automatic applyStimulus(input vec_t v, input bit hold, input bit abort, output int p);
    exp_t it;
    @(negedge clk);
    cmd_op = v.op; cmd_amt = v.amt; cmd_data = v.data; cmd_fill = v.fill;
    cmd_valid = 1'b1;
    p = -1;
    for (int t = 0; t < 64; t++) begin
      if (cmd_ready) begin
        p = cyc;
        break;
      end
      @(negedge clk);
    end
    if (p < 0) begin
      timeout_count++;
      $display("[TB] FAIL accept_timeout cyc=%0d actual=no_ready required=ready", cyc);
      cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i < v.n; i++) begin
      if (abort && i > 0) break;
      it.kind = 1'b0; it.cyc = p + 1 + i; it.ctrl = v.op;
      it.num = (i == 0) ? v.s0 : v.s1;
      it.data = v.data; it.fill = v.fill; it.regval = 8'h00;
      sb.push_back(it);
    end
    if (!abort) begin
      it.kind = 1'b1; it.cyc = p + v.n + 1; it.ctrl = 2'b00; it.num = 3'd0;
      it.data = v.data; it.fill = v.fill; it.regval = v.regval;
      sb.push_back(it);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) return;
    end
    timeout_count++;
    $display("[TB] FAIL idle_timeout cyc=%0d actual=pending=%0d required=pending=0", cyc, sb.size());
  endtask

  function automatic vec_t mkVec(input logic [1:0] op, input logic [AW-1:0] amt, input logic [7:0] data,
                                 input logic fill, input int n, input logic [2:0] s0, input logic [2:0] s1,
                                 input logic [7:0] regval);
    vec_t v;
    v.op = op; v.amt = amt; v.data = data; v.fill = fill;
    v.n = n; v.s0 = s0; v.s1 = s1; v.regval = regval;
    return v;
  endfunction

  task automatic runCmd(input vec_t v);
    int p;
    applyStimulus(v, 1'b0, 1'b0, p);
    waitIdle();
  endtask

  initial begin
    int p1, p2, p3;
    $display("[TB] start");
    clr = 1'b0;
    repeat (3) @(negedge clk);
    pushSnap("reset_state", cyc + 1, RESET_VAL, ALL_MASK);
    @(negedge clk);
    clr = 1'b1;

    //        op     amt    data   fill N  s0    s1    register after
    runCmd(mkVec(2'b01, 4'd0,  8'hA5, 1'b0, 1, 3'd0, 3'd0, 8'hA5));
    runCmd(mkVec(2'b01, 4'd0,  8'h01, 1'b0, 1, 3'd0, 3'd0, 8'h01));
    runCmd(mkVec(2'b10, 4'd9,  8'h00, 1'b0, 2, 3'd7, 3'd1, 8'h00));
    runCmd(mkVec(2'b01, 4'd0,  8'h80, 1'b0, 1, 3'd0, 3'd0, 8'h80));
    runCmd(mkVec(2'b11, 4'd3,  8'h00, 1'b1, 1, 3'd3, 3'd0, 8'hF0));
    runCmd(mkVec(2'b10, 4'd0,  8'h00, 1'b1, 0, 3'd0, 3'd0, 8'hF0));
    runCmd(mkVec(2'b00, 4'd5,  8'hFF, 1'b0, 0, 3'd0, 3'd0, 8'hF0));

    // Back-to-back with cmd_valid held: second command enters on the
    // cycle cmd_ready returns, four cycles after the first acceptance.
    applyStimulus(mkVec(2'b11, 4'd15, 8'h00, 1'b0, 2, 3'd7, 3'd1, 8'h00), 1'b1, 1'b0, p1);
    pushSnap("b2b_done_cycle", p1 + 3, {1'b0, 1'b1, 1'b1, 2'b00, 3'd0, 10'b0}, CTRL_MASK);
    pushSnap("b2b_ready_cycle", p1 + 4, {1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 10'b0}, CTRL_MASK);
    pushSnap("b2b_second_issue", p1 + 5, {1'b0, 1'b1, 1'b0, 2'b10, 3'd5, 10'b0}, CTRL_MASK);
    applyStimulus(mkVec(2'b10, 4'd5, 8'h00, 1'b1, 1, 3'd5, 3'd0, 8'h1F), 1'b0, 1'b0, p2);
    waitIdle();

    runCmd(mkVec(2'b10, 4'd7,  8'h00, 1'b0, 1, 3'd7, 3'd0, 8'h80));
    runCmd(mkVec(2'b11, 4'd8,  8'h00, 1'b1, 2, 3'd7, 3'd1, 8'hFF));

    // Reset during the first ISSUE cycle abandons the command silently.
    applyStimulus(mkVec(2'b10, 4'd8, 8'h00, 1'b0, 2, 3'd7, 3'd1, 8'h00), 1'b0, 1'b1, p3);
    clr = 1'b0;
    pushSnap("reset_mid_issue", p3 + 2, RESET_VAL, ALL_MASK);
    @(negedge clk);
    clr = 1'b1;
    repeat (6) @(negedge clk);

    runCmd(mkVec(2'b01, 4'd0,  8'h3C, 1'b1, 1, 3'd0, 3'd0, 8'h3C));

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
